mem_ctrl: RTL

Memory controller between the CPU core and the 8-bit external RAM bus. It arbitrates between the instruction-fetch port and the MEM-stage data port and serialises each 1/2/4-byte access into little-endian byte transfers. It sign- or zero-extends load results and stalls IO writes while the UART buffer is full. It sits at the top level, directly below the core: the MEM stage's read/write/length/signed/ready handshake and the IF stage's fetch handshake both terminate here.

---
 rtl/mem_ctrl_pkg.sv | 54 +++++
 rtl/mem_ctrl_if.sv | 52 +++++
 rtl/mem_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared definitions: FSM states, access lengths, IO decode, helpers.
package mem_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned IO_BIT_DEF = 17;

   // Two address bits [IO_BIT:IO_BIT-1] equal to this select IO space
   localparam logic [1:0] IO_SPACE = 2'b11;

   localparam logic [2:0] LEN_B = 3'd1;
   localparam logic [2:0] LEN_H = 3'd2;
   localparam logic [2:0] LEN_W = 3'd4;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE
   } state_t;

   typedef enum logic {
      SRC_IF,
      SRC_MEM
   } src_t;

   // Requester length code to byte count: 1 and 2 are literal, anything else is a word
   function automatic logic [2:0] len_decode(input logic [2:0] len);
      case (len)
         3'd1:    len_decode = LEN_B;
         3'd2:    len_decode = LEN_H;
         default: len_decode = LEN_W;
      endcase
   endfunction

   // Little-endian byte lane i of a word
   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
      case (i)
         2'd0:    byte_sel = w[7:0];
         2'd1:    byte_sel = w[15:8];
         2'd2:    byte_sel = w[23:16];
         default: byte_sel = w[31:24];
      endcase
   endfunction

   // Load result extension; words pass through untouched
   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] n,
                                          input logic sgn);
      case (n)
         LEN_B:   extend = {{24{sgn & raw[7]}}, raw[7:0]};
         LEN_H:   extend = {{16{sgn & raw[15]}}, raw[15:0]};
         default: extend = raw;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl bus bundle: IF fetch port, MEM data port, external 8-bit RAM bus, IO flow control.
interface mem_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   // IF stage fetch handshake
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [31:0]       if_data;

   // MEM stage data handshake
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [2:0]        mem_length;
   logic              mem_signed;
   logic              mem_ready;
   logic [31:0]       mem_rdata;

   // External RAM byte bus
   logic [ADDR_W-1:0] ram_a;
   logic [7:0]        ram_dout;
   logic [7:0]        ram_din;
   logic              ram_wr;

   // UART sink back-pressure
   logic              io_buffer_full;

   // Controller side
   modport slave (
      input  if_req, if_addr,
      output if_ready, if_data,
      input  mem_read, mem_write, mem_addr, mem_wdata, mem_length, mem_signed,
      output mem_ready, mem_rdata,
      output ram_a, ram_dout, ram_wr,
      input  ram_din,
      input  io_buffer_full
   );

   // Core / RAM / IO side
   modport master (
      output if_req, if_addr,
      input  if_ready, if_data,
      output mem_read, mem_write, mem_addr, mem_wdata, mem_length, mem_signed,
      input  mem_ready, mem_rdata,
      input  ram_a, ram_dout, ram_wr,
      output ram_din,
      output io_buffer_full
   );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF fetches and MEM loads/stores onto an 8-bit little-endian RAM bus.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned IO_BIT = IO_BIT_DEF
) (
   input logic       clk,
   input logic       rst,
   input logic       rdy,
   mem_ctrl_if.slave bus
);

   state_t            state, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        n_q, n_d;
   logic              sgn_q, sgn_d;
   src_t              src_q, src_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [31:0]       asm_q, asm_d;

   logic [ADDR_W-1:0] ram_a_q, ram_a_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic              ram_wr_q, ram_wr_d;
   logic              if_ready_q, if_ready_d;
   logic              mem_ready_q, mem_ready_d;
   logic [31:0]       if_data_q, if_data_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;

   logic              accept;
   logic              mem_sel;
   logic              is_store;
   logic              io_req;
   logic              io_q;
   logic              stall;
   logic [2:0]        cnt_inc;

   // A ready pulse still pending blocks acceptance, so a request held into its own ready cycle is not re-taken
   assign accept   = (bus.mem_read | bus.mem_write | bus.if_req) & ~if_ready_q & ~mem_ready_q;
   assign mem_sel  = bus.mem_read | bus.mem_write;
   assign is_store = ~bus.mem_read & bus.mem_write;
   assign io_req   = (bus.mem_addr[IO_BIT -: 2] == IO_SPACE);
   assign io_q     = (addr_q[IO_BIT -: 2] == IO_SPACE);
   assign stall    = io_q & bus.io_buffer_full;
   assign cnt_inc  = cnt_q + 3'd1;

   // State register; rdy low freezes the FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (rdy) begin
         state <= state_d;
      end
   end

   // Next-state: READ ends after the last byte capture, WRITE after the last driven byte
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_d = is_store ? WRITE : READ;
            end
         end
         READ: begin
            if (cnt_q == n_q) begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (ram_wr_q && (cnt_inc == n_q)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values; every bus output is registered from these
   always_comb begin
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      n_d         = n_q;
      sgn_d       = sgn_q;
      src_d       = src_q;
      cnt_d       = cnt_q;
      asm_d       = asm_q;
      ram_a_d     = ram_a_q;
      ram_dout_d  = ram_dout_q;
      ram_wr_d    = 1'b0;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      unique case (state)
         IDLE: begin
            if (accept) begin
               cnt_d = '0;
               asm_d = '0;
               if (mem_sel) begin
                  addr_d  = bus.mem_addr;
                  wdata_d = bus.mem_wdata;
                  n_d     = len_decode(bus.mem_length);
                  sgn_d   = bus.mem_signed;
                  src_d   = SRC_MEM;
               end else begin
                  addr_d  = bus.if_addr;
                  wdata_d = '0;
                  n_d     = LEN_W;
                  sgn_d   = 1'b0;
                  src_d   = SRC_IF;
               end
               ram_a_d = addr_d;
               if (is_store) begin
                  ram_dout_d = bus.mem_wdata[7:0];
                  ram_wr_d   = ~(io_req & bus.io_buffer_full);
               end
            end
         end
         READ: begin
            // cnt_q counts READ cycles: byte cnt_q is on the address bus, byte cnt_q-1 is on ram_din
            for (int unsigned k = 0; k < 4; k++) begin
               if (cnt_q == 3'(k + 1)) begin
                  asm_d[8*k +: 8] = bus.ram_din;
               end
            end
            cnt_d = cnt_inc;
            if (cnt_inc < n_q) begin
               ram_a_d = addr_q + ADDR_W'(cnt_inc);
            end
            if (cnt_q == n_q) begin
               cnt_d = '0;
               if (src_q == SRC_MEM) begin
                  mem_ready_d = 1'b1;
                  mem_rdata_d = extend(asm_d, n_q, sgn_q);
               end else begin
                  if_ready_d = 1'b1;
                  if_data_d  = asm_d;
               end
            end
         end
         WRITE: begin
            // A byte retires only in a cycle where it was actually strobed; an IO stall re-offers it
            if (ram_wr_q) begin
               cnt_d = cnt_inc;
               if (cnt_inc == n_q) begin
                  cnt_d       = '0;
                  mem_ready_d = 1'b1;
                  mem_rdata_d = '0;
               end else begin
                  ram_a_d    = addr_q + ADDR_W'(cnt_inc);
                  ram_dout_d = byte_sel(wdata_q, cnt_inc[1:0]);
                  ram_wr_d   = ~stall;
               end
            end else begin
               ram_wr_d = ~stall;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers; rdy low holds everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         n_q         <= '0;
         sgn_q       <= 1'b0;
         src_q       <= SRC_IF;
         cnt_q       <= '0;
         asm_q       <= '0;
         ram_a_q     <= '0;
         ram_dout_q  <= '0;
         ram_wr_q    <= 1'b0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
      end else if (rdy) begin
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         n_q         <= n_d;
         sgn_q       <= sgn_d;
         src_q       <= src_d;
         cnt_q       <= cnt_d;
         asm_q       <= asm_d;
         ram_a_q     <= ram_a_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // Strobes are masked by rdy so a frozen cycle never writes RAM or signals completion
   assign bus.ram_a     = ram_a_q;
   assign bus.ram_dout  = ram_dout_q;
   assign bus.ram_wr    = ram_wr_q & rdy;
   assign bus.if_ready  = if_ready_q & rdy;
   assign bus.if_data   = if_data_q;
   assign bus.mem_ready = mem_ready_q & rdy;
   assign bus.mem_rdata = mem_rdata_q;

endmodule
